tx_arb: RTL and testbench

TX_ARB -- requirements
Module: tx_arb

---
 rtl/com_pkg.sv | 26 ++
 rtl/rr_pick.sv | 39 +++
 rtl/tx_arb.sv | 148 ++++++++++++++
 tb/tb_tx_arb.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/com_pkg.sv
// com_pkg: shared constants and types for the UART transmit arbiter.
//   state_t      - arbiter FSM encoding (IDLE / LOAD / SEND)
//   NREQ_DEF     - default requester count
//   GAP_MAX_DEF  - default mid-packet idle tolerance, in CLK cycles
//   CLK_FREQ     - system clock, Hz
//   BAUD         - uart_tx line rate; BAUD_DIV is the clocks-per-bit ratio
//   idx_w()      - width of a requester index (never below 1 bit)
package com_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam int NREQ_DEF    = 4;
    localparam int GAP_MAX_DEF = 1200;   // 100 us at 12 MHz
    localparam int CLK_FREQ    = 12_000_000;
    localparam int BAUD        = 115200;
    localparam int BAUD_DIV    = CLK_FREQ / BAUD;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// rr_pick: combinational round-robin selector.
//   req   - request vector
//   ptr   - index of the last winner; the search starts at ptr+1
//   grant - one-hot winner (all zero when nothing requests)
//   idx   - binary index of the winner
//   valid - at least one request present
module rr_pick
    import com_pkg::*;
#(
    parameter int  NREQ = NREQ_DEF,
    localparam int IW   = idx_w(NREQ)
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic [NREQ-1:0] grant,
    output logic [IW-1:0]   idx,
    output logic            valid
);

    logic [IW-1:0] pos;

    // Walk ptr+1 .. ptr+NREQ (mod NREQ); the last candidate is ptr itself,
    // so the previous winner only wins again when nobody else asks.
    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        pos   = '0;
        for (int k = 1; k <= NREQ; k++) begin
            pos = IW'((int'(ptr) + k) % NREQ);
            if (!valid && req[pos]) begin
                valid      = 1'b1;
                idx        = pos;
                grant[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tx_arb.sv
// tx_arb: packet-level round-robin arbiter in front of one external uart_tx.
//   CLK, RST  - single clock, synchronous active-high reset
//   REQ       - per-requester byte valid, held until ACK
//   LAST      - per-requester end-of-packet flag, qualified by REQ
//   DATA      - per-requester byte, requester i on DATA[8i+7:8i]
//   ACK       - one-cycle pulse, byte taken
//   GRANT     - one-hot packet owner, zero when idle
//   TX_START  - start strobe to uart_tx, held until TX_BUSY seen high
//   TX_DATA   - byte to uart_tx
//   TX_BUSY   - busy flag from uart_tx
// A grant lasts for a whole packet (through the LAST byte) so packets never
// interleave; an owner that stalls mid-packet for GAP_MAX cycles loses it.
module tx_arb
    import com_pkg::*;
#(
    parameter int NREQ    = NREQ_DEF,
    parameter int GAP_MAX = GAP_MAX_DEF
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [NREQ-1:0]   REQ,
    input  logic [NREQ-1:0]   LAST,
    input  logic [8*NREQ-1:0] DATA,
    output logic [NREQ-1:0]   ACK,
    output logic [NREQ-1:0]   GRANT,
    output logic              TX_START,
    output logic [7:0]        TX_DATA,
    input  logic              TX_BUSY
);

    localparam int IW = idx_w(NREQ);
    localparam int GW = $clog2(GAP_MAX + 1);

    state_t          state_q, state_n;
    logic [NREQ-1:0] grant_q, grant_n;
    logic [NREQ-1:0] ack_q, ack_n;
    logic            start_q, start_n;
    logic [7:0]      data_q, data_n;
    logic            last_q, last_n;
    logic [GW-1:0]   gap_q, gap_n;
    logic [IW-1:0]   ptr_q, ptr_n;
    logic [IW-1:0]   gidx_q, gidx_n;

    logic [NREQ-1:0] pick_grant;
    logic [IW-1:0]   pick_idx;
    logic            pick_valid;

    rr_pick #(.NREQ(NREQ)) u_pick (
        .req   (REQ),
        .ptr   (ptr_q),
        .grant (pick_grant),
        .idx   (pick_idx),
        .valid (pick_valid)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            grant_q <= '0;
            ack_q   <= '0;
            start_q <= 1'b0;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
            gap_q   <= '0;
            ptr_q   <= IW'(NREQ - 1);   // requester 0 is searched first
            gidx_q  <= '0;
        end else begin
            state_q <= state_n;
            grant_q <= grant_n;
            ack_q   <= ack_n;
            start_q <= start_n;
            data_q  <= data_n;
            last_q  <= last_n;
            gap_q   <= gap_n;
            ptr_q   <= ptr_n;
            gidx_q  <= gidx_n;
        end
    end

    always_comb begin
        state_n = state_q;
        grant_n = grant_q;
        ack_n   = '0;
        start_n = start_q;
        data_n  = data_q;
        last_n  = last_q;
        gap_n   = gap_q;
        ptr_n   = ptr_q;
        gidx_n  = gidx_q;

        case (state_q)
            ST_IDLE: begin
                if (pick_valid) begin
                    grant_n = pick_grant;
                    gidx_n  = pick_idx;
                    gap_n   = '0;
                    state_n = ST_LOAD;
                end
            end

            ST_LOAD: begin
                if (REQ[gidx_q]) begin
                    data_n  = DATA[{gidx_q, 3'b000} +: 8];
                    last_n  = LAST[gidx_q];
                    ack_n   = grant_q;
                    gap_n   = '0;
                    state_n = ST_SEND;
                end else if (gap_q == GW'(GAP_MAX - 1)) begin
                    // Owner went quiet mid-packet: drop it, no ACK.
                    grant_n = '0;
                    ptr_n   = gidx_q;
                    gap_n   = '0;
                    state_n = ST_IDLE;
                end else begin
                    gap_n = gap_q + 1'b1;
                end
            end

            ST_SEND: begin
                // REQ is ignored here: the latched byte goes out regardless.
                if (!TX_BUSY && !start_q) begin
                    start_n = 1'b1;
                end else if (TX_BUSY && start_q) begin
                    start_n = 1'b0;
                    if (last_q) begin
                        grant_n = '0;
                        ptr_n   = gidx_q;
                        state_n = ST_IDLE;
                    end else begin
                        state_n = ST_LOAD;
                    end
                end
            end

            default: begin
                grant_n = '0;
                start_n = 1'b0;
                state_n = ST_IDLE;
            end
        endcase
    end

    assign ACK      = ack_q;
    assign GRANT    = grant_q;
    assign TX_START = start_q;
    assign TX_DATA  = data_q;

endmodule

// File: tb/tb_tx_arb.sv
`timescale 1ns/1ps
// tb_tx_arb: directed and random checks of tx_arb against a uart_tx model
// and a per-requester byte scoreboard.
module tb_tx_arb;

    localparam int N   = 4;
    localparam int GAP = 40;

    logic           CLK;
    logic           RST;
    logic [N-1:0]   REQ, LAST, ACK, GRANT;
    logic [8*N-1:0] DATA;
    logic           TX_START;
    logic [7:0]     TX_DATA;
    logic           TX_BUSY;
    logic           bfm_busy, man_busy, bz_edge;

    assign TX_BUSY = bfm_busy | man_busy;

    tx_arb #(.NREQ(N), .GAP_MAX(GAP)) dut (
        .CLK      (CLK),
        .RST      (RST),
        .REQ      (REQ),
        .LAST     (LAST),
        .DATA     (DATA),
        .ACK      (ACK),
        .GRANT    (GRANT),
        .TX_START (TX_START),
        .TX_DATA  (TX_DATA),
        .TX_BUSY  (TX_BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // busy value the DUT sampled at the latest rising edge
    always @(posedge CLK) bz_edge <= TX_BUSY;

    int n_chk = 0, n_bad = 0;
    int n_sent = 0, n_pushed = 0;
    int open_owner = -1;
    logic [8:0] pq  [N][$];   // bytes still to present, {last, data}
    logic [8:0] exq [N][$];   // bytes still expected on the line
    int log_r[$];             // owner of every byte seen on the line

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_chk++;
        if (got !== want) begin
            n_bad++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    task automatic push_byte(input int r, input logic [7:0] d, input logic l);
        pq[r].push_back({l, d});
        exq[r].push_back({l, d});
        n_pushed++;
    endtask

    task automatic clear_q();
        for (int i = 0; i < N; i++) begin
            pq[i].delete();
            exq[i].delete();
        end
        log_r.delete();
        open_owner = -1;
    endtask

    function automatic bit quiet();
        for (int i = 0; i < N; i++)
            if (pq[i].size() != 0) return 1'b0;
        return (REQ == '0) && (GRANT == '0) && !TX_BUSY && !TX_START;
    endfunction

    task automatic drain(input int budget);
        int k = 0;
        @(negedge CLK);
        while (k < budget && !quiet()) begin
            @(negedge CLK);
            k++;
        end
        if (k >= budget) chk("drain_timeout", 1, 0);
    endtask

    task automatic wait_start(input logic lvl, input int budget, input string tag);
        int k = 0;
        while (k < budget && TX_START !== lvl) begin
            @(negedge CLK);
            k++;
        end
        chk(tag, TX_START, lvl);
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        man_busy = 1'b0;
        clear_q();
        repeat (2) @(negedge CLK);
        chk("rst_grant", GRANT, 0);
        chk("rst_ack", ACK, 0);
        chk("rst_start", TX_START, 0);
        chk("rst_txdata", TX_DATA, 0);
        RST = 1'b0;
    endtask

    task automatic sb_capture(input logic [7:0] d, input logic [N-1:0] g);
        int r = -1;
        logic [8:0] e;
        for (int i = 0; i < N; i++)
            if (g[i]) r = i;
        n_sent++;
        chk("sb_owner_valid", (r >= 0), 1);
        if (r >= 0) begin
            log_r.push_back(r);
            chk("sb_pending", (exq[r].size() > 0), 1);
            if (exq[r].size() > 0) begin
                e = exq[r].pop_front();
                chk("sb_data", d, e[7:0]);
                if (open_owner >= 0) chk("sb_interleave", r, open_owner);
                open_owner = e[8] ? -1 : r;
            end
        end
    endtask

    // requesters: present queue head, pop on ACK
    initial begin : drv
        logic [8:0] e;
        REQ = '0; LAST = '0; DATA = '0;
        forever begin
            @(negedge CLK);
            for (int i = 0; i < N; i++) begin
                if (ACK[i] && pq[i].size() > 0) void'(pq[i].pop_front());
                if (pq[i].size() > 0) begin
                    e = pq[i][0];
                    REQ[i]  = 1'b1;
                    LAST[i] = e[8];
                    DATA[8*i +: 8] = e[7:0];
                end else begin
                    REQ[i]  = 1'b0;
                    LAST[i] = 1'b0;
                end
            end
        end
    end

    // uart_tx model: busy 1..3 cycles after start, busy for 2..6 cycles
    initial begin : bfm
        bfm_busy = 1'b0;
        forever begin
            @(negedge CLK);
            if (TX_START && !TX_BUSY) begin
                sb_capture(TX_DATA, GRANT);
                repeat ($urandom_range(1, 3) - 1) @(negedge CLK);
                bfm_busy = 1'b1;
                repeat ($urandom_range(2, 6)) @(negedge CLK);
                bfm_busy = 1'b0;
            end
        end
    end

    // protocol monitor
    initial begin : mon
        logic st_prev;
        st_prev = 1'b0;
        forever begin
            @(negedge CLK);
            if (TX_START && !st_prev) chk("start_while_busy", bz_edge, 0);
            if (ACK != '0) begin
                chk("ack_onehot", $countones(ACK), 1);
                chk("ack_owner", ACK, GRANT);
            end
            st_prev = TX_START;
        end
    end

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog time limit");
        $fatal(1, "watchdog");
    end

    initial begin : main
        bit seen;
        int cnt, r, len, left;
        RST = 1'b1;
        man_busy = 1'b0;

        // first-transaction latency
        do_reset();
        push_byte(0, 8'h41, 1'b1);
        seen = 1'b0;
        for (int k = 0; k < 6 && !seen; k++) begin
            @(posedge CLK);
            seen = REQ[0];
        end
        chk("lat_req_seen", seen, 1);
        @(negedge CLK);
        chk("lat_grant_n1", GRANT, 4'b0001);
        chk("lat_ack_n1", ACK, 0);
        @(negedge CLK);
        chk("lat_ack_n2", ACK, 4'b0001);
        chk("lat_start_n2", TX_START, 0);
        chk("lat_txdata", TX_DATA, 8'h41);
        @(negedge CLK);
        chk("lat_start_n3", TX_START, 1);
        drain(200);

        // all four requesting single-byte packets: 0,1,2,3,0,1,2,3
        do_reset();
        for (int p = 0; p < 2; p++)
            for (int i = 0; i < N; i++)
                push_byte(i, 8'(16 * p + i + 1), 1'b1);
        drain(600);
        chk("rr_count", log_r.size(), 8);
        for (int i = 0; i < 8; i++)
            if (i < log_r.size()) chk("rr_order", log_r[i], i % 4);

        // five-byte packet from 1 is not split by a waiting requester 2
        do_reset();
        push_byte(1, 8'h44, 1'b0);
        push_byte(1, 8'h33, 1'b0);
        push_byte(1, 8'h41, 1'b0);
        push_byte(1, 8'h35, 1'b0);
        push_byte(1, 8'h0A, 1'b1);
        push_byte(2, 8'h77, 1'b1);
        drain(600);
        chk("pkt_count", log_r.size(), 6);
        for (int i = 0; i < 6; i++)
            if (i < log_r.size()) chk("pkt_order", log_r[i], (i < 5) ? 1 : 2);

        // owner stalls mid-packet: grant revoked GAP cycles into LOAD
        do_reset();
        push_byte(3, 8'hC3, 1'b0);
        wait_start(1'b1, 100, "gap_start_hi");
        wait_start(1'b0, 100, "gap_start_lo");
        push_byte(0, 8'h5A, 1'b1);
        push_byte(1, 8'h6B, 1'b1);
        repeat (GAP - 1) @(negedge CLK);
        chk("gap_hold", GRANT, 4'b1000);
        @(negedge CLK);
        chk("gap_revoke", GRANT, 0);
        open_owner = -1;
        drain(600);
        chk("gap_log_count", log_r.size(), 3);
        if (log_r.size() >= 2) chk("gap_next_owner", log_r[1], 0);

        // reset mid-packet while uart_tx is busy
        do_reset();
        man_busy = 1'b1;
        push_byte(2, 8'h21, 1'b0);
        push_byte(2, 8'h22, 1'b1);
        cnt = 0;
        while (cnt < 20 && !ACK[2]) begin
            @(negedge CLK);
            cnt++;
        end
        chk("rst_mid_ack", ACK[2], 1);
        repeat (3) @(negedge CLK);
        chk("busy_hold_start", TX_START, 0);
        RST = 1'b1;
        clear_q();
        @(negedge CLK);
        chk("rst_mid_grant", GRANT, 0);
        chk("rst_mid_ack0", ACK, 0);
        chk("rst_mid_start", TX_START, 0);
        RST = 1'b0;
        push_byte(1, 8'h99, 1'b1);
        cnt = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge CLK);
            if (TX_START) cnt++;
        end
        chk("no_start_busy", cnt, 0);
        chk("rst_mid_regrant", GRANT, 4'b0010);
        man_busy = 1'b0;
        wait_start(1'b1, 20, "start_after_busy");
        drain(200);
        chk("rst_mid_log", log_r.size(), 1);
        if (log_r.size() > 0) chk("rst_mid_owner", log_r[0], 1);

        // 1000 random packets through the scoreboard
        do_reset();
        n_sent = 0;
        n_pushed = 0;
        for (int p = 0; p < 1000; p++) begin
            r   = $urandom_range(0, N - 1);
            len = $urandom_range(1, 3);
            for (int b = 0; b < len; b++)
                push_byte(r, 8'($urandom), (b == len - 1));
            repeat ($urandom_range(0, 6)) @(negedge CLK);
        end
        drain(60000);
        chk("rand_bytes", n_sent, n_pushed);
        left = 0;
        for (int i = 0; i < N; i++) left += exq[i].size();
        chk("rand_leftover", left, 0);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
